// File: rtl/aes_pkg.sv
`default_nettype none
// aes_pkg: constants and types shared by the AES-128 key schedule and the cipher core.
// Rev 1.0
package aes_pkg;

  localparam int AES_NK = 4;
  localparam int AES_NR = 10;

  // Indexed by round number; entry 0 and entries past round 10 are never used.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef logic [31:0] word_t;

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// aes_sbox: combinational AES forward S-box, one byte per instance.
// Rev 1.0
module aes_sbox (
  input  logic [7:0] byte_in,
  output logic [7:0] byte_out
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign byte_out = SBOX[byte_in];

endmodule
`default_nettype wire

// File: rtl/aes128_key_expand.sv
`default_nettype none
// aes128_key_expand: iterative AES-128 key schedule, one round key per clock into an 11-slot bus.
// Rev 1.0
module aes128_key_expand
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [127:0]  key_in,
  input  logic          key_load,
  output logic          busy,
  output logic          keys_valid,
  output logic [1407:0] round_keys
);

  localparam int KEY_W = 32 * AES_NK;

  state_t           state;
  logic [3:0]       rnd;
  logic [KEY_W-1:0] slots [0:AES_NR];

  logic [KEY_W-1:0] prev_key;
  logic [KEY_W-1:0] next_key;
  word_t            w0, w1, w2, w3;
  word_t            rot, sub, t;
  word_t            n0, n1, n2, n3;
  logic [7:0]       rcon_byte;

  // Previous round key is the slot just below rnd; rnd is never 0 while expanding.
  always_comb begin
    prev_key = '0;
    for (int i = 0; i < AES_NR; i++) begin
      if (rnd == 4'(i + 1)) prev_key = slots[i];
    end
  end

  assign {w0, w1, w2, w3} = prev_key;
  assign rot              = {w3[23:0], w3[31:24]};
  assign rcon_byte        = RCON[rnd];

  generate
    for (genvar g = 0; g < 4; g++) begin : g_subword
      aes_sbox u_sbox (
        .byte_in  (rot[8*g +: 8]),
        .byte_out (sub[8*g +: 8])
      );
    end
  endgenerate

  assign t        = sub ^ {rcon_byte, 24'h0};
  assign n0       = w0 ^ t;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rnd        <= 4'd0;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      for (int i = 0; i <= AES_NR; i++) slots[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (key_load) begin
            slots[0] <= key_in;
            for (int i = 1; i <= AES_NR; i++) slots[i] <= '0;
            rnd        <= 4'd1;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
            state      <= EXPAND;
          end
        end
        EXPAND: begin
          for (int i = 1; i <= AES_NR; i++) begin
            if (rnd == 4'(i)) slots[i] <= next_key;
          end
          rnd <= rnd + 4'd1;
          if (rnd == 4'(AES_NR)) begin
            busy       <= 1'b0;
            keys_valid <= 1'b1;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  generate
    for (genvar r = 0; r <= AES_NR; r++) begin : g_round_keys
      assign round_keys[KEY_W*r +: KEY_W] = slots[r];
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/aes128_key_expand.md
# aes128_key_expand

Iterative AES-128 key-schedule unit that sits directly upstream of the pipelined AES-128 encryption core. It accepts a 128-bit cipher key and computes all 11 round keys (FIPS-197 KeyExpansion), one round key per clock. It presents them on a flat bus that the core's 10 round stages tap in parallel. A `keys_valid` flag tells the block-issue logic when the schedule is stable and blocks may enter the pipeline.

## Interface
- No parameters. AES-128 only; Nk=4 and Nr=10 are fixed package constants.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `key_in`  in  128  cipher key; byte 0 is `key_in[127:120]`, FIPS-197 order.
- `key_load`  in  1  single-cycle request to expand `key_in`.
- `busy`  out  1  expansion in progress.
- `keys_valid`  out  1  `round_keys` complete and stable.
- `round_keys`  out  1408  round key r at `[128*r +: 128]`, r=0..10; r=0 equals the loaded key.

## Operation
- States: IDLE, EXPAND, DONE.
  - IDLE→EXPAND on `key_load`.
  - EXPAND→DONE when round 10 is written.
  - DONE→EXPAND on `key_load`.
  - Any state→IDLE on `reset`.
- Load edge:
  - Writes `round_keys` slot 0 with `key_in`.
  - Sets `rnd`=1 and `busy`=1.
  - Clears `keys_valid`.
  - Zeroes slots 1..10.
- Each EXPAND edge computes slot `rnd` from slot `rnd`-1 (words w0..w3):
  - `t` = SubWord(RotWord(w3)) ^ {Rcon[rnd],24'h0}.
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
  - `rnd` then increments.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. Rcon is a package constant table, not computed at runtime.
- `key_load` while `busy`=1 is ignored. The current expansion continues unchanged.
- `key_load` in DONE restarts the expansion. `keys_valid` falls on that same edge.
- `key_in` is sampled only on the load edge and may change afterwards.
- Slots are written only by the load edge and by EXPAND edges. In DONE they hold their values indefinitely.

## Timing
- Reset values:
  - `busy`=0, `keys_valid`=0, `round_keys`=0.
  - State IDLE, `rnd`=0.
- Load accepted at edge T0. Slot r is written at edge T0+r.
- At edge T10:
  - `busy` falls.
  - `keys_valid` rises.
  - State becomes DONE.
- Latency from the load edge to `keys_valid` high is exactly 10 cycles.
- `busy` is high for exactly 10 cycles per accepted load.
- Reset mid-expansion:
  - Aborts the expansion and returns all outputs to reset values on that edge.
  - A `key_load` in the same cycle as `reset` is ignored.
- Combinational path per cycle: one S-box level plus a 4-deep XOR chain. No multicycle paths.
- All outputs are registered.

## Structure
- Package `aes_pkg` holds:
  - Constants `AES_NK`=4, `AES_NR`=10.
  - The `RCON` table.
  - The state enum {IDLE, EXPAND, DONE}.
  - The round-key word typedef (32 bits).
- Sub-module `aes_sbox`: 8-bit combinational S-box lookup. It is instantiated 4 times for SubWord and is shared with the encryption core's SubBytes.
- Top holds:
  - The FSM.
  - The 4-bit `rnd` counter.
  - The 11×128 slot register array.
  - The single-round word-recurrence logic.

## Test plan
- FIPS-197 C.1 key `000102030405060708090a0b0c0d0e0f`, pulse `key_load`:
  - slot 1 = `d6aa74fdd2af72fadaa678f1d6ab76fe`.
  - slot 10 = `13111d7fe3944a17f307a78b4d2b30c5`.
  - `keys_valid` rises exactly 10 cycles after the load edge.
- Key `2b7e151628aed2a6abf7158809cf4f3c`:
  - slot 1 = `a0fafe1788542cb123a339392a6c7605`.
  - slot 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6`.
  - `busy` high for 10 cycles.
- All-zero key:
  - slot 1 = `62636363626363636263636362636363`.
  - slot 10 = `b4ef5bcb3e92e21123e951cf6f8f188e`.
- Second `key_load` with a different key at cycle 4 of an expansion:
  - The load is ignored.
  - The result matches the first key.
  - `keys_valid` still rises at T10.
- Reload in DONE with the C.1 key, after a first expansion of the zero key:
  - `keys_valid` drops on the load edge.
  - Slots 1..10 read 0 during the expansion.
  - `keys_valid` re-asserts 10 cycles later with the C.1 values.
- `reset` asserted at cycle 5 of an expansion:
  - All outputs go to 0 the next cycle and the state is IDLE.
  - A subsequent load completes normally in 10 cycles.
